conv_filter_stream: RTL and testbench
=====================================

Name: conv_filter_stream

Overview:
- Parametrised streaming convolution-filter MAC; successor to the fixed 5x5x3 filter.
- Accepts one signed weight/data pair per valid/ready beat and accumulates FILTER_HEIGHT*FILTER_WIDTH*FILTER_CHANNEL products plus a bias.
- Emits one saturated 2*BITWIDTH result per window on a valid/ready output with back-pressure.
- Sits between the feature-map/weight fetch logic and the pooling/activation stage of the LeNet5 datapath.

Parameters:
- BITWIDTH, 8, signed width of weight and data.
- FILTER_HEIGHT, 5, kernel rows.
- FILTER_WIDTH, 5, kernel columns.
- FILTER_CHANNEL, 3, input channels per window.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  weight/data/bias valid.
- in_ready  out  1  block accepts a beat.
- weight  in  BITWIDTH  signed weight.
- data  in  BITWIDTH  signed activation.
- bias  in  2*BITWIDTH  signed bias; sampled on the first beat of a window only.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- result  out  2*BITWIDTH  signed, saturated window sum.
- sat  out  1  result was clamped; qualified by out_valid.

Behaviour:
- Interface (decided): one clock, clk; reset is synchronous and active-high, named reset.
- Derived constants:
  - N = FILTER_HEIGHT*FILTER_WIDTH*FILTER_CHANNEL.
  - CNT_W = clog2(N).
  - ACC_W = 2*BITWIDTH + clog2(N) + 1.
- Reset outputs: in_ready=0 during reset, 1 on the first cycle after; out_valid=0, result=0, sat=0.
- Reset internal state: state=S_ACCUM, element counter cnt=0, product-valid=0, acc=0.
- Beat: accepted when in_valid && in_ready at a rising edge.
- FSM states: S_ACCUM, S_FLUSH, S_OUT.
- S_ACCUM:
  - in_ready=1.
  - Each beat registers the full-width signed product weight*data plus first/last tags: first = cnt==0, last = cnt==N-1.
  - cnt increments per beat; it wraps to 0 and moves to S_FLUSH on the last beat.
  - The first beat also latches bias.
  - in_valid low stalls with no state change, and gaps are allowed anywhere in a window.
- Accumulate stage (runs whenever the product register is valid):
  - first tag: acc <= sext(bias_reg) + sext(product).
  - otherwise: acc <= acc + sext(product).
  - The combined first+last case (N=1) is legal.
- S_FLUSH: in_ready=0; waits one cycle for the last product to reach the accumulator.
- Result latch: when the last-tagged product accumulates, the sum is clamped to [-2^(2B-1), 2^(2B-1)-1] and written to result; sat=1 if clamped; out_valid<=1; state goes to S_OUT.
- Latency: last beat at edge k -> out_valid high after edge k+2.
- S_OUT:
  - in_ready=0.
  - result and sat are held stable while out_valid && !out_ready.
  - On the out_valid && out_ready edge: out_valid<=0, state->S_ACCUM.
  - in_ready becomes 1 the following cycle.
- Throughput: N+3 cycles per window minimum.
- Width rule: ACC_W guarantees no internal overflow; saturation happens only at the output.
- Reset mid-window or mid-output: everything returns to reset values, partial sums are discarded, and the next beat is treated as a first beat.
- Beats presented while in_ready=0 are not consumed; the upstream holds them.

Optional Feature:
- Macro: CONV_FILTER_RELU_EN.
- Defined: after saturation, a negative result is replaced by 0. sat still reports clamping that occurred before the ReLU.
- Undefined: result is the signed saturated sum; negative values pass through.

Decomposition:
- Package conv_filter_pkg holds:
  - the N, CNT_W and ACC_W derivation functions;
  - the state enum (S_ACCUM, S_FLUSH, S_OUT);
  - a sat_clamp function (ACC_W -> 2*BITWIDTH).
- One natural sub-module: conv_mac_pipe, covering the product register, tags and accumulator. The top keeps the FSM, counter, bias latch, output register and handshake.

Test Plan:
- 75 beats of weight=1, data=1, bias=0, out_ready=1 -> result=75, sat=0, out_valid exactly 2 cycles after the last beat.
- bias=-10, weight=2, data=-1 for all 75 beats -> result=-160; with CONV_FILTER_RELU_EN -> result=0.
- Saturation:
  - weight=127, data=127, bias=32767 -> result=32767, sat=1.
  - weight=-128, data=127, bias=-32768 -> result=-32768, sat=1.
- Back-pressure: out_ready low for 5 cycles -> result stable, in_ready=0. Release, then start a back-to-back second window (weight=1, data=2, bias=5) -> result=155.
- Random in_valid gaps (~30% idle) over a window of weight=3, data=-2, bias=100 -> result=-350, with the count unaffected by gaps.
- Assert reset after 40 beats, then feed a full 75-beat window (weight=1, data=1, bias=1) -> result=76, with no residue from the aborted window.

Source files
------------

// File: rtl/conv_filter_pkg.sv
// Shared types and helpers for the streaming convolution-filter MAC:
// derived-size functions, the control FSM state type and the output clamp.
package conv_filter_pkg;

  typedef enum logic [1:0] {
    S_ACCUM = 2'd0,
    S_FLUSH = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  // Working width used by the clamp helpers; wide enough for any practical ACC_W.
  localparam int CLAMP_W = 64;

  // Number of products per window.
  function automatic int calc_n(input int h, input int w, input int c);
    return h * w * c;
  endfunction

  // Element counter width; kept at least one bit so a 1-element window still has a counter.
  function automatic int calc_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Accumulator width: full product width plus growth for n terms plus one for the bias add.
  function automatic int calc_acc_w(input int bw, input int n);
    return 2 * bw + $clog2(n) + 1;
  endfunction

  // Clamp a sign-extended accumulator value into a signed res_w-bit range.
  function automatic logic signed [CLAMP_W-1:0] sat_clamp(input logic signed [CLAMP_W-1:0] acc,
                                                          input int res_w);
    logic signed [CLAMP_W-1:0] max_v;
    logic signed [CLAMP_W-1:0] min_v;
    max_v = (64'sd1 <<< (res_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (res_w - 1));
    if (acc > max_v) begin
      return max_v;
    end else if (acc < min_v) begin
      return min_v;
    end else begin
      return acc;
    end
  endfunction

  // True when sat_clamp would change the value.
  function automatic logic sat_hit(input logic signed [CLAMP_W-1:0] acc, input int res_w);
    logic signed [CLAMP_W-1:0] max_v;
    logic signed [CLAMP_W-1:0] min_v;
    max_v = (64'sd1 <<< (res_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (res_w - 1));
    return (acc > max_v) || (acc < min_v);
  endfunction

endpackage

// File: rtl/conv_mac_pipe.sv
// Two-stage MAC pipe: registered signed product with first/last tags, then
// an accumulator that restarts from the bias on a first-tagged product.
// done_o pulses for one cycle after the last-tagged product has been added.
module conv_mac_pipe
  import conv_filter_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int ACC_W    = 24
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         beat_i,
  input  logic                         first_i,
  input  logic                         last_i,
  input  logic signed [BITWIDTH-1:0]   weight_i,
  input  logic signed [BITWIDTH-1:0]   data_i,
  input  logic signed [2*BITWIDTH-1:0] bias_i,
  output logic signed [ACC_W-1:0]      acc_o,
  output logic                         done_o
);

  localparam int PW = 2 * BITWIDTH;

  logic signed [PW-1:0]    w_ext_s;
  logic signed [PW-1:0]    d_ext_s;
  logic signed [ACC_W-1:0] bias_ext_s;
  logic signed [ACC_W-1:0] prod_ext_s;

  logic signed [PW-1:0]    prod_q,   prod_d;
  logic                    first_q,  first_d;
  logic                    last_q,   last_d;
  logic                    pvalid_q, pvalid_d;
  logic signed [ACC_W-1:0] acc_q,    acc_d;
  logic                    done_q,   done_d;

  // The full signed product of two BITWIDTH values always fits in 2*BITWIDTH bits.
  assign w_ext_s    = {{BITWIDTH{weight_i[BITWIDTH-1]}}, weight_i};
  assign d_ext_s    = {{BITWIDTH{data_i[BITWIDTH-1]}}, data_i};
  assign bias_ext_s = {{(ACC_W-PW){bias_i[PW-1]}}, bias_i};
  assign prod_ext_s = {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};

  // Next-state for the product register and the accumulator.
  always_comb begin
    prod_d   = prod_q;
    first_d  = first_q;
    last_d   = last_q;
    pvalid_d = 1'b0;
    acc_d    = acc_q;
    done_d   = 1'b0;
    if (beat_i) begin
      prod_d   = w_ext_s * d_ext_s;
      first_d  = first_i;
      last_d   = last_i;
      pvalid_d = 1'b1;
    end else begin
      prod_d   = prod_q;
      pvalid_d = 1'b0;
    end
    if (pvalid_q) begin
      if (first_q) begin
        acc_d = bias_ext_s + prod_ext_s;
      end else begin
        acc_d = acc_q + prod_ext_s;
      end
      done_d = last_q;
    end else begin
      acc_d  = acc_q;
      done_d = 1'b0;
    end
  end

  // Pipe registers with synchronous reset discarding any partial sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q   <= {PW{1'b0}};
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      pvalid_q <= 1'b0;
      acc_q    <= {ACC_W{1'b0}};
      done_q   <= 1'b0;
    end else begin
      prod_q   <= prod_d;
      first_q  <= first_d;
      last_q   <= last_d;
      pvalid_q <= pvalid_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
    end
  end

  assign acc_o  = acc_q;
  assign done_o = done_q;

endmodule

// File: rtl/conv_filter_stream.sv
// Streaming convolution-filter MAC: accumulates one window of
// FILTER_HEIGHT*FILTER_WIDTH*FILTER_CHANNEL weight*data products plus a bias
// and emits one saturated 2*BITWIDTH result per window with back-pressure.
// Optional build macro CONV_FILTER_RELU_EN: negative saturated results become 0
// (sat still reports clamping that happened before the ReLU).
module conv_filter_stream
  import conv_filter_pkg::*;
#(
  parameter int BITWIDTH       = 8,
  parameter int FILTER_HEIGHT  = 5,
  parameter int FILTER_WIDTH   = 5,
  parameter int FILTER_CHANNEL = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [BITWIDTH-1:0]   weight,
  input  logic signed [BITWIDTH-1:0]   data,
  input  logic signed [2*BITWIDTH-1:0] bias,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [2*BITWIDTH-1:0] result,
  output logic                         sat
);

  localparam int N     = calc_n(FILTER_HEIGHT, FILTER_WIDTH, FILTER_CHANNEL);
  localparam int CNT_W = calc_cnt_w(N);
  localparam int ACC_W = calc_acc_w(BITWIDTH, N);
  localparam int RES_W = 2 * BITWIDTH;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [RES_W-1:0] bias_q, bias_d;
  logic signed [RES_W-1:0] result_q, result_d;
  logic                    sat_q, sat_d;
  logic                    out_valid_q, out_valid_d;
  logic                    in_ready_q, in_ready_d;

  logic                      beat_s;
  logic                      first_s;
  logic                      last_s;
  logic signed [ACC_W-1:0]   acc_s;
  logic                      mac_done_s;
  logic signed [CLAMP_W-1:0] acc_wide_s;
  logic signed [RES_W-1:0]   clamp_s;
  logic                      clamp_sat_s;
  logic signed [RES_W-1:0]   res_s;

  assign beat_s  = in_valid && in_ready_q;
  assign first_s = (cnt_q == {CNT_W{1'b0}});
  assign last_s  = (cnt_q == CNT_LAST);

  conv_mac_pipe #(
    .BITWIDTH (BITWIDTH),
    .ACC_W    (ACC_W)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .beat_i   (beat_s),
    .first_i  (first_s),
    .last_i   (last_s),
    .weight_i (weight),
    .data_i   (data),
    .bias_i   (first_s ? bias : bias_q),
    .acc_o    (acc_s),
    .done_o   (mac_done_s)
  );

  // Saturation happens only here; the accumulator is sized never to overflow.
  assign acc_wide_s  = {{(CLAMP_W-ACC_W){acc_s[ACC_W-1]}}, acc_s};
  assign clamp_s     = RES_W'(sat_clamp(acc_wide_s, RES_W));
  assign clamp_sat_s = sat_hit(acc_wide_s, RES_W);

`ifdef CONV_FILTER_RELU_EN
  assign res_s = clamp_s[RES_W-1] ? {RES_W{1'b0}} : clamp_s;
`else
  assign res_s = clamp_s;
`endif

  // Control FSM: window counting, bias latch, result latch and output handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bias_d      = bias_q;
    result_d    = result_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_ACCUM: begin
        if (beat_s) begin
          cnt_d   = last_s ? {CNT_W{1'b0}} : (cnt_q + CNT_ONE);
          bias_d  = first_s ? bias : bias_q;
          state_d = last_s ? S_FLUSH : S_ACCUM;
        end else begin
          state_d = S_ACCUM;
        end
      end
      S_FLUSH: begin
        if (mac_done_s) begin
          result_d    = res_s;
          sat_d       = clamp_sat_s;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_OUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_ACCUM;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d     = S_ACCUM;
        cnt_d       = {CNT_W{1'b0}};
        out_valid_d = 1'b0;
      end
    endcase
    in_ready_d = (state_d == S_ACCUM);
  end

  // State and output registers; synchronous reset drops any window in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_ACCUM;
      cnt_q       <= {CNT_W{1'b0}};
      bias_q      <= {RES_W{1'b0}};
      result_q    <= {RES_W{1'b0}};
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bias_q      <= bias_d;
      result_q    <= result_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_conv_filter_stream.sv
// Self-checking bench for conv_filter_stream: directed windows from the test
// plan plus randomized windows, checked against a plain-arithmetic window model.
module tb_conv_filter_stream;

  localparam int BW = 8;
  localparam int FH = 5;
  localparam int FW = 5;
  localparam int FC = 3;
  localparam int NB = FH * FW * FC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [BW-1:0]   weight;
  logic signed [BW-1:0]   data;
  logic signed [2*BW-1:0] bias;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [2*BW-1:0] result;
  logic                   sat;

  int vectors    = 0;
  int miscompares = 0;
  int w_arr [NB];
  int d_arr [NB];

  conv_filter_stream #(
    .BITWIDTH       (BW),
    .FILTER_HEIGHT  (FH),
    .FILTER_WIDTH   (FW),
    .FILTER_CHANNEL (FC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .weight    (weight),
    .data      (data),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .sat       (sat)
  );

  // Reference: bias plus the dot product of the window, then clamp (and ReLU).
  function automatic longint model_sum(input int b);
    longint s = longint'(b);
    for (int i = 0; i < NB; i++) s += longint'(w_arr[i]) * longint'(d_arr[i]);
    return s;
  endfunction

  function automatic logic signed [2*BW-1:0] model_result(input longint s);
    longint c = s;
    if (c > 32767) c = 32767;
    if (c < -32768) c = -32768;
`ifdef CONV_FILTER_RELU_EN
    if (c < 0) c = 0;
`endif
    return 16'(c);
  endfunction

  function automatic logic model_sat(input longint s);
    return (s > 32767) || (s < -32768);
  endfunction

  task automatic fill_const(input int w, input int d);
    for (int i = 0; i < NB; i++) begin
      w_arr[i] = w;
      d_arr[i] = d;
    end
  endtask

  // Drive n beats from w_arr/d_arr; non-first beats carry junk bias. Called and returns at a negedge.
  task automatic send_window(input int n, input int b, input int gap_pct, output bit to);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 4000) begin
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        weight   = 8'($urandom);
        data     = 8'($urandom);
        bias     = 16'($urandom);
      end else begin
        in_valid = 1'b1;
        weight   = 8'(w_arr[i]);
        data     = 8'(d_arr[i]);
        bias     = (i == 0) ? 16'(b) : 16'($urandom);
      end
      if (in_valid && in_ready) i++;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    to = (i < n);
  endtask

  // Count cycles until out_valid is seen (bounded).
  task automatic wait_out(output int lat, output bit to);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    to = !out_valid;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    weight = 8'sd0; data = 8'sd0; bias = 16'sd0;
    repeat (3) @(negedge clk);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (result !== 16'sd0) begin miscompares++; $display("FAIL reset_result: got %0d want 0", result); end
    vectors++; if (sat !== 1'b0) begin miscompares++; $display("FAIL reset_sat: got %b want 0", sat); end
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_ones_latency;
    bit to; int lat;
    logic signed [2*BW-1:0] exp_r;
    fill_const(1, 1);
    exp_r = model_result(model_sum(0));
    send_window(NB, 0, 0, to);
    vectors++; if (to) begin miscompares++; $display("FAIL ones_send_timeout: got stall want %0d beats", NB); end
    wait_out(lat, to);
    vectors++; if (to) begin miscompares++; $display("FAIL ones_out_timeout: got none want out_valid"); end
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL ones_latency: got %0d want 2", lat); end
    vectors++; if (result !== exp_r) begin miscompares++; $display("FAIL ones_result: got %0d want %0d", result, exp_r); end
    vectors++; if (sat !== 1'b0) begin miscompares++; $display("FAIL ones_sat: got %b want 0", sat); end
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ones_drop_valid: got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ones_ready_again: got %b want 1", in_ready); end
  endtask

  // Table: {weight, data, bias} windows covering negative sum and both saturation rails.
  task automatic test_sign_and_saturation;
    int tw [3] = '{2, 127, -128};
    int td [3] = '{-1, 127, 127};
    int tb [3] = '{-10, 32767, -32768};
    bit to; int lat; longint s;
    for (int k = 0; k < 3; k++) begin
      fill_const(tw[k], td[k]);
      s = model_sum(tb[k]);
      send_window(NB, tb[k], 0, to);
      wait_out(lat, to);
      vectors++; if (to) begin miscompares++; $display("FAIL sat%0d_timeout: got none want out_valid", k); end
      vectors++; if (result !== model_result(s)) begin miscompares++; $display("FAIL sat%0d_result: got %0d want %0d", k, result, model_result(s)); end
      vectors++; if (sat !== model_sat(s)) begin miscompares++; $display("FAIL sat%0d_flag: got %b want %b", k, sat, model_sat(s)); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    bit to; int lat;
    logic signed [2*BW-1:0] exp_r;
    fill_const(1, 1);
    exp_r = model_result(model_sum(0));
    out_ready = 1'b0;
    send_window(NB, 0, 0, to);
    wait_out(lat, to);
    vectors++; if (to) begin miscompares++; $display("FAIL bp_timeout: got none want out_valid"); end
    for (int c = 0; c < 5; c++) begin
      // Offered beats must not be consumed while the result is held.
      in_valid = 1'b1; weight = 8'sd100; data = 8'sd100; bias = 16'sd7;
      @(negedge clk);
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid%0d: got %b want 1", c, out_valid); end
      vectors++; if (result !== exp_r) begin miscompares++; $display("FAIL bp_hold_result%0d: got %0d want %0d", c, result, exp_r); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_hold_ready%0d: got %b want 0", c, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    fill_const(1, 2);
    exp_r = model_result(model_sum(5));
    send_window(NB, 5, 0, to);
    wait_out(lat, to);
    vectors++; if (to) begin miscompares++; $display("FAIL b2b_timeout: got none want out_valid"); end
    vectors++; if (result !== exp_r) begin miscompares++; $display("FAIL b2b_result: got %0d want %0d", result, exp_r); end
    @(negedge clk);
  endtask

  task automatic test_gaps;
    bit to; int lat;
    logic signed [2*BW-1:0] exp_r;
    fill_const(3, -2);
    exp_r = model_result(model_sum(100));
    send_window(NB, 100, 30, to);
    wait_out(lat, to);
    vectors++; if (to) begin miscompares++; $display("FAIL gaps_timeout: got none want out_valid"); end
    vectors++; if (result !== exp_r) begin miscompares++; $display("FAIL gaps_result: got %0d want %0d", result, exp_r); end
    vectors++; if (sat !== 1'b0) begin miscompares++; $display("FAIL gaps_sat: got %b want 0", sat); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_window;
    bit to; int lat;
    logic signed [2*BW-1:0] exp_r;
    fill_const(5, 7);
    send_window(40, 50, 0, to);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    fill_const(1, 1);
    exp_r = model_result(model_sum(1));
    send_window(NB, 1, 0, to);
    wait_out(lat, to);
    vectors++; if (to) begin miscompares++; $display("FAIL rstmid_timeout: got none want out_valid"); end
    vectors++; if (result !== exp_r) begin miscompares++; $display("FAIL rstmid_result: got %0d want %0d", result, exp_r); end
    @(negedge clk);
  endtask

  task automatic test_random;
    bit to; int lat; int b; longint s;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NB; i++) begin
        w_arr[i] = int'($urandom_range(255)) - 128;
        d_arr[i] = int'($urandom_range(255)) - 128;
      end
      b = int'($urandom_range(65535)) - 32768;
      s = model_sum(b);
      send_window(NB, b, 20, to);
      out_ready = 1'b0;
      wait_out(lat, to);
      repeat ($urandom_range(3)) @(negedge clk);
      vectors++; if (to) begin miscompares++; $display("FAIL rnd%0d_timeout: got none want out_valid", k); end
      vectors++; if (result !== model_result(s)) begin miscompares++; $display("FAIL rnd%0d_result: got %0d want %0d", k, result, model_result(s)); end
      vectors++; if (sat !== model_sat(s)) begin miscompares++; $display("FAIL rnd%0d_sat: got %b want %b", k, sat, model_sat(s)); end
      out_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_ones_latency();
    test_sign_and_saturation();
    test_back_to_back();
    test_gaps();
    test_reset_mid_window();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
